// File: rtl/rename_unit.sv
// rename_unit
//   Register-rename stage feeding physical_register_file. Keeps a register
//   alias table (architectural -> physical) and a circular free list of
//   physical registers. Physical register 0 is the hardwired zero and is
//   never handed out or returned.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   ren_valid/ren_ready         upstream handshake (ready is combinational)
//   ren_src1/ren_src2/ren_dst   architectural operands, ren_dst_en = writes dst
//   out_valid/out_ready         downstream handshake, 1-cycle registered output
//   out_psrc1/out_psrc2         physical sources (PRF read_dir1/read_dir2)
//   out_pdst                    allocated physical destination (PRF write_dir)
//   out_old_pdst                previous mapping of ren_dst, freed at commit
//   free_en/free_dir            commit returns a physical register
//   free_count                  entries currently in the free list
//   overflow_err                sticky: a return was attempted with the list full
module rename_unit #(
  parameter int ARCH_WIDTH = 5,
  parameter int DIR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  ren_valid,
  output logic                  ren_ready,
  input  logic [ARCH_WIDTH-1:0] ren_src1,
  input  logic [ARCH_WIDTH-1:0] ren_src2,
  input  logic [ARCH_WIDTH-1:0] ren_dst,
  input  logic                  ren_dst_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIR_WIDTH-1:0]  out_psrc1,
  output logic [DIR_WIDTH-1:0]  out_psrc2,
  output logic [DIR_WIDTH-1:0]  out_pdst,
  output logic [DIR_WIDTH-1:0]  out_old_pdst,
  input  logic                  free_en,
  input  logic [DIR_WIDTH-1:0]  free_dir,
  output logic [DIR_WIDTH-1:0]  free_count,
  output logic                  overflow_err
);

  localparam int NUM_ARCH  = 2**ARCH_WIDTH;
  localparam int NUM_PHYS  = 2**DIR_WIDTH;
  localparam int INIT_FREE = NUM_PHYS - NUM_ARCH;
  localparam logic [DIR_WIDTH-1:0] INIT_FREE_D = DIR_WIDTH'(INIT_FREE);
  localparam logic [DIR_WIDTH-1:0] NUM_ARCH_D  = DIR_WIDTH'(NUM_ARCH);

  logic [DIR_WIDTH-1:0] rat_q [NUM_ARCH];
  logic [DIR_WIDTH-1:0] rat_d [NUM_ARCH];
  logic [DIR_WIDTH-1:0] list_mem [NUM_PHYS];

  logic [DIR_WIDTH-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [DIR_WIDTH-1:0] lim_q, lim_d;
  logic                 out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [DIR_WIDTH-1:0] psrc1_q, psrc1_d, psrc2_q, psrc2_d;
  logic [DIR_WIDTH-1:0] pdst_q, pdst_d, old_q, old_d;

  logic                 accept, alloc, free_req, list_full, push;
  logic [DIR_WIDTH-1:0] pop_dir;

  assign ren_ready = (!out_valid_q || out_ready) && (count_q != '0);

  // The list storage cannot be cleared by reset, so its initial contents
  // (index i holds i+NUM_ARCH for i < INIT_FREE) are synthesised on read.
  // Pushes fill the low region strictly in order after the tail wraps, so
  // lim_q marks how many low entries have been rewritten since reset.
  always_comb begin
    accept    = ren_valid && ren_ready;
    alloc     = accept && ren_dst_en && (ren_dst != '0);
    free_req  = free_en && (free_dir != '0);
    list_full = (count_q == '1);
    push      = free_req && !list_full;

    if ((head_q < INIT_FREE_D) && (head_q >= lim_q)) begin
      pop_dir = head_q + NUM_ARCH_D;
    end else begin
      pop_dir = list_mem[head_q];
    end

    head_d  = alloc ? head_q + 1'b1 : head_q;
    tail_d  = push  ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (alloc && !push) count_d = count_q - 1'b1;
    if (push && !alloc) count_d = count_q + 1'b1;

    lim_d = lim_q;
    if (push && (tail_q < INIT_FREE_D) && (tail_q == lim_q)) lim_d = lim_q + 1'b1;

    ovf_d = ovf_q || (free_req && list_full);

    rat_d = rat_q;
    if (alloc) rat_d[ren_dst] = pop_dir;

    out_valid_d = out_valid_q;
    psrc1_d     = psrc1_q;
    psrc2_d     = psrc2_q;
    pdst_d      = pdst_q;
    old_d       = old_q;
    if (accept) begin
      out_valid_d = 1'b1;
      // Sources see the table before this instruction's own update.
      psrc1_d     = rat_q[ren_src1];
      psrc2_d     = rat_q[ren_src2];
      pdst_d      = alloc ? pop_dir : '0;
      old_d       = alloc ? rat_q[ren_dst] : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= DIR_WIDTH'(i);
      head_q      <= '0;
      tail_q      <= INIT_FREE_D;
      count_q     <= INIT_FREE_D;
      lim_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      psrc1_q     <= '0;
      psrc2_q     <= '0;
      pdst_q      <= '0;
      old_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= rat_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      lim_q       <= lim_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      psrc1_q     <= psrc1_d;
      psrc2_q     <= psrc2_d;
      pdst_q      <= pdst_d;
      old_q       <= old_d;
    end
  end

  // Free list storage: no reset, written at the tail.
  always_ff @(posedge clk) begin
    if (push) list_mem[tail_q] <= free_dir;
  end

  assign out_valid    = out_valid_q;
  assign out_psrc1    = psrc1_q;
  assign out_psrc2    = psrc2_q;
  assign out_pdst     = pdst_q;
  assign out_old_pdst = old_q;
  assign free_count   = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       ren_valid = 1'b0, ren_ready, ren_dst_en = 1'b0;
  logic [4:0] ren_src1 = '0, ren_src2 = '0, ren_dst = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [9:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
  logic       free_en = 1'b0;
  logic [9:0] free_dir = '0;
  logic [9:0] free_count;
  logic       overflow_err;

  int n_chk = 0;
  int n_fail = 0;

  rename_unit #(.ARCH_WIDTH(5), .DIR_WIDTH(10)) dut (
    .clk(clk), .arst_n(arst_n),
    .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_src1(ren_src1), .ren_src2(ren_src2), .ren_dst(ren_dst), .ren_dst_en(ren_dst_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psrc1(out_psrc1), .out_psrc2(out_psrc2), .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
    .free_en(free_en), .free_dir(free_dir), .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int rat [32];
  int fq [$];
  bit m_valid, m_ovf;
  int m_ps1, m_ps2, m_pd, m_old;

  function automatic bit m_ready();
    return (!m_valid || out_ready) && (fq.size() != 0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fq.delete();
    for (int i = 32; i < 1024; i++) fq.push_back(i);
    m_valid = 0; m_ovf = 0;
    m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_old = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        m_reset();
      end else begin
        bit acc;
        bit do_push;
        acc = ren_valid && m_ready();
        do_push = 0;
        if (free_en && free_dir != 0) begin
          if (fq.size() == 1023) m_ovf = 1;
          else do_push = 1;
        end
        if (acc) begin
          m_valid = 1;
          m_ps1 = rat[ren_src1];
          m_ps2 = rat[ren_src2];
          if (ren_dst_en && ren_dst != 0) begin
            m_pd  = fq.pop_front();
            m_old = rat[ren_dst];
            rat[ren_dst] = m_pd;
          end else begin
            m_pd = 0; m_old = 0;
          end
        end else if (out_ready) begin
          m_valid = 0;
        end
        if (do_push) fq.push_back(int'(free_dir));
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("ren_ready", int'(ren_ready), int'(m_ready()));
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("free_count", int'(free_count), fq.size());
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
    if (m_valid) begin
      chk("out_psrc1", int'(out_psrc1), m_ps1);
      chk("out_psrc2", int'(out_psrc2), m_ps2);
      chk("out_pdst", int'(out_pdst), m_pd);
      chk("out_old_pdst", int'(out_old_pdst), m_old);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input int s1, input int s2, input int d, input bit de,
                     input bit ordy, input bit fe, input int fd);
    ren_valid  = v;
    ren_src1   = 5'(s1);
    ren_src2   = 5'(s2);
    ren_dst    = 5'(d);
    ren_dst_en = de;
    out_ready  = ordy;
    free_en    = fe;
    free_dir   = 10'(fd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    arst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int cnt;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    do_reset();
    chk("rst_count", int'(free_count), 992);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pdst", int'(out_pdst), 0);

    // 1: basic allocation and forwarding of the new mapping
    cyc(1, 3, 4, 5, 1, 1, 0, 0);
    $display("T1 accept: psrc1=%0d psrc2=%0d pdst=%0d old=%0d cnt=%0d", out_psrc1, out_psrc2, out_pdst, out_old_pdst, free_count);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_psrc1", int'(out_psrc1), 3);
    chk("t1_psrc2", int'(out_psrc2), 4);
    chk("t1_pdst", int'(out_pdst), 32);
    chk("t1_old", int'(out_old_pdst), 5);
    chk("t1_count", int'(free_count), 991);
    cyc(1, 5, 0, 0, 0, 1, 0, 0);
    chk("t1_fwd", int'(out_psrc1), 32);

    // 2: src == dst sees the old mapping
    cyc(1, 7, 0, 7, 1, 1, 0, 0);
    chk("t2_psrc1", int'(out_psrc1), 7);
    chk("t2_pdst", int'(out_pdst), 33);
    cyc(1, 7, 0, 0, 0, 1, 0, 0);
    chk("t2_fwd", int'(out_psrc1), 33);

    // 3: destination r0 never allocates
    cyc(1, 0, 0, 0, 1, 1, 0, 0);
    chk("t3_pdst", int'(out_pdst), 0);
    chk("t3_old", int'(out_old_pdst), 0);
    chk("t3_psrc1", int'(out_psrc1), 0);
    chk("t3_count", int'(free_count), 990);

    // 4: drain the list, then return one register
    for (int i = 0; i < 2000; i++) begin
      if (!ren_ready) break;
      cyc(1, i % 32, (i + 1) % 32, (i % 31) + 1, 1, 1, 0, 0);
    end
    $display("T4 drained: cnt=%0d ready=%0d", free_count, ren_ready);
    chk("t4_empty", int'(free_count), 0);
    chk("t4_ready", int'(ren_ready), 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 40);
    chk("t4_cnt1", int'(free_count), 1);
    chk("t4_ready1", int'(ren_ready), 1);
    cyc(1, 0, 0, 9, 1, 1, 0, 0);
    chk("t4_pdst40", int'(out_pdst), 40);

    // wrap the tail into the low region and allocate back through it
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0, 1, 1, 100 + i);
    chk("wrap_cnt", int'(free_count), 100);
    cyc(1, 1, 2, 3, 1, 1, 0, 0);
    chk("wrap_first", int'(out_pdst), 100);
    for (int i = 1; i < 100; i++) cyc(1, i % 32, 0, (i % 31) + 1, 1, 1, 0, 0);
    chk("wrap_last", int'(out_pdst), 199);

    // 5: back-pressure
    do_reset();
    cyc(1, 1, 2, 3, 1, 1, 0, 0);
    cnt = int'(free_count);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4, 5, 6, 1, 0, 0, 0);
      $display("T5 stall %0d: ready=%0d pdst=%0d cnt=%0d", i, ren_ready, out_pdst, free_count);
      chk("t5_ready", int'(ren_ready), 0);
      chk("t5_pdst", int'(out_pdst), 32);
      chk("t5_count", int'(free_count), cnt);
    end
    cyc(1, 3, 5, 6, 1, 1, 0, 0);
    chk("t5_psrc1", int'(out_psrc1), 32);
    chk("t5_pdst2", int'(out_pdst), 33);

    // 6: simultaneous pop and push, overflow, async reset
    cnt = int'(free_count);
    cyc(1, 0, 0, 8, 1, 1, 1, 50);
    chk("t6_same", int'(free_count), cnt);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 1, 1, i + 1);
    chk("t6_full", int'(free_count), 1023);
    chk("t6_ovf", int'(overflow_err), 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_sticky", int'(overflow_err), 1);
    cyc(1, 2, 3, 4, 1, 1, 0, 0);
    chk("t6_pre_valid", int'(out_valid), 1);
    #2 arst_n = 1'b0;
    #1;
    $display("T6 async reset: valid=%0d cnt=%0d ovf=%0d", out_valid, free_count, overflow_err);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_count", int'(free_count), 992);
    chk("t6_rst_ovf", int'(overflow_err), 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    arst_n = 1'b1;
    cyc(1, 5, 6, 0, 0, 1, 0, 0);
    chk("t6_rat5", int'(out_psrc1), 5);
    chk("t6_rat6", int'(out_psrc2), 6);
    cyc(1, 4, 8, 0, 0, 1, 0, 0);
    chk("t6_rat4", int'(out_psrc1), 4);
    chk("t6_rat8", int'(out_psrc2), 8);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
